// File: rtl/capture_pkg.sv
// Shared types and constants for the capture controller and its sample memory.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_TRIG,
        POST,
        READ
    } cap_state_t;

    // Cycles from read-address issue to data on the RAM output.
    localparam int RD_LAT = 1;

endpackage

// File: rtl/sample_ram.sv
// Single-clock simple dual-port sample memory with a registered read port.
module sample_ram #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 1024
) (
    input  logic                      clock_i,
    input  logic                      we_i,
    input  logic [$clog2(DEPTH)-1:0]  waddr_i,
    input  logic [SAMPLE_WIDTH-1:0]   wdata_i,
    input  logic                      re_i,
    input  logic [$clog2(DEPTH)-1:0]  raddr_i,
    output logic [SAMPLE_WIDTH-1:0]   rdata_o
);

    logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];

    // Write port and synchronous read port; contents are never cleared.
    always_ff @(posedge clock_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/capture_controller.sv
// Capture FSM: fills pre-trigger history, arms the trigger, records the
// trigger point, captures post-trigger samples and streams the window out.
module capture_controller
    import capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_W:0]         pre_count,
    input  logic [ADDR_W:0]         post_count,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic                    run,
    output logic                    arm,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done
);

    localparam int              CW      = ADDR_W + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    cap_state_t state_q, state_d;
    logic [CW-1:0]     pre_q, pre_d, post_q, post_d;
    logic [CW-1:0]     fill_q, fill_d, pcnt_q, pcnt_d, left_q, left_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_q, trig_d;
    logic              arm_q, arm_d, done_q, done_d;
    // Read pipeline: RAM stage, output register, skid register.
    logic              ram_v_q, ram_v_d, ram_last_q, ram_last_d;
    logic              out_v_q, out_v_d, out_last_q, out_last_d;
    logic              skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic [SAMPLE_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic [SAMPLE_WIDTH-1:0] ram_rdata;

    logic              wr_en, issue, pop, go_read;
    logic [CW-1:0]     wr_inc, pre_c, post_c, room;

    assign wr_en  = valid && (state_q == FILL || state_q == WAIT_TRIG || state_q == POST);
    assign wr_inc = CW'(wr_en);

    // Clamp requested counts so the window never exceeds the memory.
    assign pre_c  = (pre_count > DEPTH_C) ? DEPTH_C : pre_count;
    assign room   = DEPTH_C - pre_c;
    assign post_c = (post_count > room) ? room : post_count;

    sample_ram #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .DEPTH(DEPTH)) u_ram (
        .clock_i (clock),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (dataIn),
        .re_i    (issue),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Next-state, counters and read pipeline steering.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        post_d      = post_q;
        fill_d      = fill_q;
        pcnt_d      = pcnt_q;
        left_d      = left_q;
        trig_d      = trig_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        arm_d       = 1'b0;
        done_d      = 1'b0;
        ram_v_d     = 1'b0;
        ram_last_d  = ram_last_q;
        out_v_d     = out_v_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        issue       = 1'b0;
        pop         = 1'b0;
        go_read     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pre_d  = pre_c;
                    post_d = post_c;
                    fill_d = '0;
                    if (pre_c == '0) begin
                        state_d = WAIT_TRIG;
                        arm_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // Count this cycle's write so arm lands right after the last fill write.
                fill_d = fill_q + wr_inc;
                if (fill_d == pre_q) begin
                    state_d = WAIT_TRIG;
                    arm_d   = 1'b1;
                end
            end
            WAIT_TRIG: begin
                // run may still be high from the previous capture while arm is out.
                if (run && !arm_q) begin
                    trig_d = wr_ptr_q;
                    pcnt_d = wr_inc;
                    if (post_q <= wr_inc) go_read = 1'b1;
                    else                  state_d = POST;
                end
            end
            POST: begin
                pcnt_d = pcnt_q + wr_inc;
                if (pcnt_d == post_q) go_read = 1'b1;
            end
            READ: begin
                pop = out_v_q && rd_ready;
                // Hold off issue when the skid is busy or the in-flight word is about to fill it.
                issue = (left_q != '0) && !skid_v_q && !(ram_v_q && out_v_q && !rd_ready);
                if (issue) begin
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    left_d     = left_q - CW'(1);
                    ram_v_d    = 1'b1;
                    ram_last_d = (left_q == CW'(1));
                end
                if (!out_v_q || pop) begin
                    if (skid_v_q) begin
                        out_v_d    = 1'b1;
                        out_data_d = skid_data_q;
                        out_last_d = skid_last_q;
                        skid_v_d   = 1'b0;
                    end else if (ram_v_q) begin
                        out_v_d    = 1'b1;
                        out_data_d = ram_rdata;
                        out_last_d = ram_last_q;
                    end else begin
                        out_v_d    = 1'b0;
                        out_last_d = 1'b0;
                    end
                end else if (ram_v_q) begin
                    skid_v_d    = 1'b1;
                    skid_data_d = ram_rdata;
                    skid_last_d = ram_last_q;
                end
                if ((pop && out_last_q) || (pre_q + post_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_read) begin
            state_d  = READ;
            rd_ptr_d = trig_d - pre_q[ADDR_W-1:0];
            left_d   = pre_q + post_q;
        end

        if (abort) begin
            state_d    = IDLE;
            arm_d      = 1'b0;
            done_d     = 1'b0;
            ram_v_d    = 1'b0;
            out_v_d    = 1'b0;
            out_last_d = 1'b0;
            skid_v_d   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            post_q      <= '0;
            fill_q      <= '0;
            pcnt_q      <= '0;
            left_q      <= '0;
            trig_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            arm_q       <= 1'b0;
            done_q      <= 1'b0;
            ram_v_q     <= 1'b0;
            ram_last_q  <= 1'b0;
            out_v_q     <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            fill_q      <= fill_d;
            pcnt_q      <= pcnt_d;
            left_q      <= left_d;
            trig_q      <= trig_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            arm_q       <= arm_d;
            done_q      <= done_d;
            ram_v_q     <= ram_v_d;
            ram_last_q  <= ram_last_d;
            out_v_q     <= out_v_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign arm      = arm_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);
    assign rd_valid = out_v_q;
    assign rd_data  = out_data_q;
    assign rd_last  = out_last_q;

endmodule

// File: doc/capture_controller.md
# capture_controller

Capture-side consumer of the trigger block's `run` output. Maintains a circular sample memory, pulses `arm` into the trigger once the requested pre-trigger history is filled, records the trigger point when `run` arrives, captures the post-trigger samples, then streams the pre-trigger and post-trigger window to the host over a valid/ready read port.

## Interface
- `SAMPLE_WIDTH`, 8, channel count and sample width; matches the trigger block.
- `DEPTH`, 1024, sample memory depth; must be a power of two.
- `ADDR_W`, $clog2(DEPTH), pointer width; derived and not overridden.
- `clock`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  host pulse that begins a capture; ignored outside IDLE.
- `abort`  in  1  returns the block to IDLE from any state.
- `pre_count`  in  ADDR_W+1  pre-trigger sample count; latched on accepted `start`.
- `post_count`  in  ADDR_W+1  post-trigger sample count; latched on accepted `start`.
- `valid`  in  1  sample strobe; shared with the trigger block.
- `dataIn`  in  SAMPLE_WIDTH  sample bus.
- `run`  in  1  trigger-fired indication from the trigger block.
- `arm`  out  1  one-cycle re-arm pulse to the trigger block.
- `rd_valid`  out  1  read data valid.
- `rd_ready`  in  1  host accepts read data.
- `rd_data`  out  SAMPLE_WIDTH  read sample.
- `rd_last`  out  1  marks the final sample of the window.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a capture completes.

## Operation
- States are IDLE, FILL, WAIT_TRIG, POST and READ.
- `wr_ptr` (ADDR_W bits) increments and wraps on every cycle where `valid` is high and the state is FILL, WAIT_TRIG or POST. `dataIn` is written at `wr_ptr` in the same cycle.
- **IDLE**
  - On `start`, latch `pre` = `pre_count` and `post` = `post_count`.
  - If `pre` + `post` > DEPTH, clamp `post` to DEPTH − `pre`. If `pre` > DEPTH, clamp `pre` to DEPTH.
  - Clear `fill_cnt` and go to FILL.
- **FILL**
  - `fill_cnt` increments once per write.
  - When `fill_cnt` equals `pre`, go to WAIT_TRIG and drive `arm` high for exactly that first WAIT_TRIG cycle. When `pre` = 0, this happens on the cycle after `start`.
- **WAIT_TRIG**
  - `run` is ignored while `arm` is high, because it may be stale.
  - On `run`, `trig_addr` = `wr_ptr` in that cycle; a write in that same cycle counts as the first post sample.
  - Clear `post_cnt` and go to POST. If `post` = 0, go directly to READ.
- **POST**
  - `post_cnt` increments per write.
  - When it reaches `post`, go to READ. The last write lands on the transition cycle.
- **READ**
  - `rd_ptr` starts at `trig_addr` − `pre`, taken modulo DEPTH.
  - Emit `pre` + `post` samples in ascending address order with wrap.
  - A transfer occurs when `rd_valid` and `rd_ready` are both high.
  - `rd_last` is high with the final sample.
  - After the final transfer, go to IDLE and pulse `done`.
  - If `pre` + `post` = 0, go to IDLE immediately and pulse `done`; `rd_valid` never asserts.
- **Handshake rule:** once `rd_valid` is asserted, `rd_data` and `rd_last` hold stable until accepted.
- **abort:** go to IDLE on the next edge, with `rd_valid` low. `done` does not pulse.
- **start:** a `start` arriving with `abort` in the same cycle is ignored.
- **reset:** `arm`, `rd_valid`, `rd_last`, `busy` and `done` reset to 0. `rd_data` resets to 0. Pointers and counters reset to 0. Memory contents are not cleared.

## Timing
- `arm` is registered and goes high the cycle after the fill condition is met.
- The trigger block clears `run` one cycle after `arm`.
- Memory read latency is 1 cycle. `rd_data` is registered, so the first `rd_valid` appears 2 cycles after entering READ.
- With `rd_ready` held high, throughput is 1 sample per cycle and there are no bubbles. This requires a prefetch/skid register.
- `done` is high in the cycle in which IDLE is entered.
- `busy` goes high in the cycle after an accepted `start`.

## Structure
- Package `capture_pkg` holds:
  - the `cap_state_t` enum (IDLE, FILL, WAIT_TRIG, POST, READ);
  - the read-latency constant `RD_LAT` = 1.
- Sub-module `sample_ram` is a simple dual-port RAM with a synchronous read port and a single clock, parameterised by `SAMPLE_WIDTH` and `DEPTH`.
- The controller holds the FSM, the pointers, the counters and the read skid register.

## Test plan
- **Basic window:** DEPTH=16, `pre`=4, `post`=4, `valid` always high, `dataIn` = counter.
  - `start`, then `run` with `dataIn`=20 → read returns 16..23.
  - `rd_last` is high on 23; `done` pulses once.
- **Arm timing:** `start` with `pre`=3 and `valid` high → `arm` is high for exactly 1 cycle, 4 cycles after `start`. A `run` held high during that cycle is ignored.
- **Wrap and clamp:** DEPTH=16, `pre`=10, `post`=10, with `trig_addr` landing at address 14 (14 samples written in total before `run`).
  - The clamp gives `post`=6.
  - 16 samples are read, starting at address 4 and wrapping through 15 to 0..3.
- **Backpressure:** `rd_ready` toggles on and off every other cycle → no sample is lost or duplicated, and `rd_data` stays stable while stalled.
- **Zero counts:** `pre`=0, `post`=0 → `arm` in the cycle after `start`, then `run`, then `done` with no `rd_valid`.
- **Abort and reset:** `abort` in POST → IDLE next edge and no `done`. `reset` in READ → all outputs 0 next cycle; a following `start` works normally.
